// File: rtl/mod_mem_access_ctrl.sv
// mod_mem_access_ctrl: MEM-stage load/store sequencer driving one Avalon-MM pipelined transaction per access.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and return misalign_o.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BYTEENABLE_WIDTH
`define BYTEENABLE_WIDTH 4
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif

module mod_mem_access_ctrl #(
    parameter int DATA_W = `XLEN,
    parameter int BE_W   = `BYTEENABLE_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_store_i,
    input  logic [`FUNCT3_WIDTH-1:0] funct3_i,
    input  logic [DATA_W-1:0]        addr_unaligned_i,
    input  logic [DATA_W-1:0]        addr_aligned_i,
    input  logic [BE_W-1:0]          byteenable_i,
    input  logic [DATA_W-1:0]        store_data_i,
    output logic [DATA_W-1:0]        avm_address_o,
    output logic                     avm_read_o,
    output logic                     avm_write_o,
    output logic [DATA_W-1:0]        avm_writedata_o,
    output logic [BE_W-1:0]          avm_byteenable_o,
    input  logic                     avm_waitrequest_i,
    input  logic                     avm_readdatavalid_i,
    input  logic [DATA_W-1:0]        avm_readdata_i,
    output logic                     rsp_valid_o,
    output logic [DATA_W-1:0]        rsp_load_data_o,
    output logic                     misalign_o
);
    typedef enum logic [1:0] {IDLE, BUS, RDATA, RESP} state_t;

    state_t                    state, next;
    logic                      store_q, mis_q, mis;
    logic [`FUNCT3_WIDTH-1:0]  f3_q;
    logic [1:0]                off_q;
    logic [DATA_W-1:0]         s, ld_ext;
    logic                      unused_addr;

    assign unused_addr = ^addr_unaligned_i[DATA_W-1:2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = (funct3_i[1:0] == 2'b01 && addr_unaligned_i[0]) ||
                 (funct3_i == 3'b010 && addr_unaligned_i[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    assign s      = avm_readdata_i >> {off_q, 3'b000};
    assign ld_ext = f3_q == 3'b000 ? {{(DATA_W-8){s[7]}}, s[7:0]} :
                    f3_q == 3'b001 ? {{(DATA_W-16){s[15]}}, s[15:0]} :
                    f3_q == 3'b010 ? s :
                    f3_q == 3'b100 ? {{(DATA_W-8){1'b0}}, s[7:0]} :
                    f3_q == 3'b101 ? {{(DATA_W-16){1'b0}}, s[15:0]} : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            store_q          <= 1'b0;
            mis_q            <= 1'b0;
            f3_q             <= '0;
            off_q            <= 2'b00;
            avm_address_o    <= '0;
            avm_writedata_o  <= '0;
            avm_byteenable_o <= '0;
            rsp_load_data_o  <= '0;
        end else begin
            state <= next;
            if (state == IDLE && req_valid_i) begin
                store_q          <= req_store_i;
                mis_q            <= mis;
                f3_q             <= funct3_i;
                off_q            <= addr_unaligned_i[1:0];
                avm_address_o    <= addr_aligned_i;
                avm_byteenable_o <= byteenable_i;
                avm_writedata_o  <= funct3_i[1:0] == 2'b10 ? store_data_i
                                    : store_data_i << {addr_unaligned_i[1:0], 3'b000};
                rsp_load_data_o  <= '0;
            end
            if (state == RDATA && avm_readdatavalid_i)
                rsp_load_data_o <= ld_ext;
        end
    end

    // Unsupported funct3 (no enables) and trapped misaligns both complete without a bus cycle.
    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = !req_valid_i ? IDLE : (byteenable_i == '0 || mis) ? RESP : BUS;
            BUS:     next = avm_waitrequest_i ? BUS : store_q ? RESP : RDATA;
            RDATA:   next = avm_readdatavalid_i ? RESP : RDATA;
            default: next = IDLE;
        endcase
    end

    assign req_ready_o = state == IDLE;
    assign avm_read_o  = state == BUS && !store_q;
    assign avm_write_o = state == BUS && store_q;
    assign rsp_valid_o = state == RESP;
    assign misalign_o  = state == RESP && mis_q;
endmodule

// File: tb/tb_mod_mem_access_ctrl.sv
// tb_mod_mem_access_ctrl: directed plus randomized accesses against a behavioural byte-lane model and bus slave.
module tb_mod_mem_access_ctrl;
    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        req_valid_i = 1'b0, req_ready_o, req_store_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_unaligned_i = '0, addr_aligned_i = '0, store_data_i = '0;
    logic [3:0]  byteenable_i = '0;
    logic [31:0] avm_address_o, avm_writedata_o, avm_readdata_i = '0, rsp_load_data_o;
    logic        avm_read_o, avm_write_o, avm_waitrequest_i = 1'b0, avm_readdatavalid_i = 1'b0;
    logic [3:0]  avm_byteenable_o;
    logic        rsp_valid_o, misalign_o;
    int          tests = 0, fails = 0;
    logic [31:0] dout;

    mod_mem_access_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_store_i(req_store_i), .funct3_i(funct3_i), .addr_unaligned_i(addr_unaligned_i),
        .addr_aligned_i(addr_aligned_i), .byteenable_i(byteenable_i), .store_data_i(store_data_i),
        .avm_address_o(avm_address_o), .avm_read_o(avm_read_o), .avm_write_o(avm_write_o),
        .avm_writedata_o(avm_writedata_o), .avm_byteenable_o(avm_byteenable_o),
        .avm_waitrequest_i(avm_waitrequest_i), .avm_readdatavalid_i(avm_readdatavalid_i),
        .avm_readdata_i(avm_readdata_i), .rsp_valid_o(rsp_valid_o),
        .rsp_load_data_o(rsp_load_data_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // access size in bytes: 1, 2, 4, or 0 for an unsupported funct3
    function automatic int size_of(input bit st, input logic [2:0] f3);
        if (f3 == 3'd0 || (!st && f3 == 3'd4)) return 1;
        if (f3 == 3'd1 || (!st && f3 == 3'd5)) return 2;
        if (f3 == 3'd2) return 4;
        return 0;
    endfunction

    function automatic logic [3:0] be_ref(input int sz, input int off);
        return sz == 1 ? 4'(2 ** off) : sz == 2 ? 4'((3 * (2 ** off)) % 16) : sz == 4 ? 4'd15 : 4'd0;
    endfunction

    function automatic bit mis_ref(input int sz, input int off);
`ifdef MEM_MISALIGN_TRAP_EN
        return (sz == 2 && off % 2 == 1) || (sz == 4 && off != 0);
`else
        return sz < 0 && off < 0;
`endif
    endfunction

    function automatic logic [31:0] wd_ref(input int sz, input int off, input logic [31:0] d);
        longint unsigned p = d;
        if (sz != 4) p = p * (64'd1 << (8 * off));
        return p[31:0];
    endfunction

    function automatic logic [31:0] ld_ref(input logic [2:0] f3, input int off, input logic [31:0] rd);
        longint unsigned v = rd;
        longint r;
        v = v / (64'd1 << (8 * off));
        if (f3 == 3'd2) return v[31:0];
        r = (f3[1:0] == 2'd0) ? longint'(v % 256) : longint'(v % 65536);
        if (f3 == 3'd0 && r >= 128) r = r - 256;
        if (f3 == 3'd1 && r >= 32768) r = r - 65536;
        return 32'(r);
    endfunction

    // Issues one request at a negedge and plays the slave; returns the response data in d.
    task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] rd, input int wt, input int lat,
                          input string tag, output logic [31:0] d);
        int sz = size_of(st, f3), off = int'(addr[1:0]);
        logic [3:0] be = be_ref(sz, off);
        bit skip = (be == 4'd0) || mis_ref(sz, off);
        int exp_cyc = skip ? 1 : st ? 2 + wt : 2 + wt + lat;
        int got = 0, nrd = 0, nwr = 0, acc = 0;
        bit unstable = 0, ready_seen = 0, both = 0, extra = 0, idle_ok = 0, mis_seen = 0;
        logic [31:0] a0 = '0, w0 = '0;
        logic [3:0]  b0 = '0;
        d = 'x;
        chk({tag, ":ready_idle"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_store_i = st; funct3_i = f3; addr_unaligned_i = addr;
        addr_aligned_i = {addr[31:2], 2'b00}; byteenable_i = be; store_data_i = sd;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (got != 0 && k == got + 1) begin
                idle_ok = !rsp_valid_o && req_ready_o;
                break;
            end
            if (avm_read_o || avm_write_o) begin
                if (nrd + nwr == 0) begin a0 = avm_address_o; w0 = avm_writedata_o; b0 = avm_byteenable_o; end
                else if (avm_address_o !== a0 || avm_writedata_o !== w0 || avm_byteenable_o !== b0) unstable = 1;
                both |= avm_read_o && avm_write_o;
                nrd += int'(avm_read_o); nwr += int'(avm_write_o);
            end
            if (rsp_valid_o) begin
                if (got == 0) begin got = k; d = rsp_load_data_o; mis_seen = misalign_o; end
                else extra = 1;
            end
            else if (req_ready_o) ready_seen = 1;
            avm_waitrequest_i = (avm_read_o || avm_write_o) && (nrd + nwr <= wt);
            if ((avm_read_o || avm_write_o) && !avm_waitrequest_i) acc = k;
            avm_readdatavalid_i = !st && acc > 0 && k == acc + lat;
            avm_readdata_i = avm_readdatavalid_i ? rd : $urandom;
            @(negedge clk_i);
        end
        avm_waitrequest_i = 1'b0; avm_readdatavalid_i = 1'b0;
        chk({tag, ":latency"}, got, exp_cyc);
        chk({tag, ":reads"}, nrd, (skip || st) ? 0 : wt + 1);
        chk({tag, ":writes"}, nwr, (skip || !st) ? 0 : wt + 1);
        chk({tag, ":ready_busy"}, 32'(ready_seen), 0);
        chk({tag, ":one_pulse_then_idle"}, 32'(!extra && idle_ok && !both && !unstable), 1);
        chk({tag, ":misalign"}, 32'(mis_seen), 32'(skip && be != 0));
        chk({tag, ":data"}, d, (skip || st) ? 32'd0 : ld_ref(f3, off, rd));
        if (!skip) begin
            chk({tag, ":addr"}, a0, {addr[31:2], 2'b00});
            chk({tag, ":be"}, 32'(b0), 32'(be));
            if (st) chk({tag, ":wdata"}, w0, wd_ref(sz, off, sd));
        end
    endtask

    initial begin
        bit          st, seen;
        logic [2:0]  f3;
        @(negedge clk_i);
        chk("reset:ready", 32'(req_ready_o), 1);
        chk("reset:strobes", {avm_read_o, avm_write_o, rsp_valid_o, misalign_o}, 0);
        chk("reset:addr", avm_address_o, 0);
        chk("reset:wdata", avm_writedata_o, 0);
        chk("reset:be", 32'(avm_byteenable_o), 0);
        chk("reset:ldata", rsp_load_data_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        access(1, 3'd0, 32'h1002, 32'h0000_00AB, 0, 0, 1, "sb", dout);
        chk("sb:wdata_held", avm_writedata_o, 32'h00AB_0000);
        chk("sb:addr_held", avm_address_o, 32'h0000_1000);
        access(0, 3'd0, 32'h2003, 0, 32'h80FF_FFFF, 0, 1, "lb", dout);
        chk("lb:value", dout, 32'hFFFF_FF80);
        access(0, 3'd4, 32'h2003, 0, 32'h80FF_FFFF, 0, 1, "lbu", dout);
        chk("lbu:value", dout, 32'h0000_0080);
        access(0, 3'd1, 32'h2002, 0, 32'h8001_1234, 3, 1, "lh_wait", dout);
        chk("lh_wait:value", dout, 32'hFFFF_8001);
        access(0, 3'd2, 32'h2000, 0, 32'hDEAD_BEEF, 0, 5, "lw_slow", dout);
        chk("lw_slow:value", dout, 32'hDEAD_BEEF);
        access(1, 3'd2, 32'h2004, 32'h1234_5678, 0, 1, 1, "sw_b2b", dout);
        access(0, 3'd2, 32'h3001, 0, 32'hA5A5_0F0F, 0, 1, "lw_mis", dout);
        access(0, 3'd1, 32'h3003, 0, 32'h9900_0000, 0, 2, "lh_trunc", dout);
        access(0, 3'd3, 32'h3000, 0, 32'h1111_1111, 0, 1, "ld_bad_f3", dout);
        access(1, 3'd3, 32'h3000, 32'h2222_2222, 0, 0, 1, "st_bad_f3", dout);

        req_valid_i = 1'b1; req_store_i = 1'b1; funct3_i = 3'd2; addr_unaligned_i = 32'h4000;
        addr_aligned_i = 32'h4000; byteenable_i = 4'hF; store_data_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        req_valid_i = 1'b0; avm_waitrequest_i = 1'b1;
        chk("rst_mid:write_before", 32'(avm_write_o), 1);
        #2 rst_ni = 1'b0;
        #1 chk("rst_mid:write_dropped", 32'(avm_write_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1; avm_waitrequest_i = 1'b0;
        seen = 0;
        repeat (4) begin @(negedge clk_i); seen |= rsp_valid_o | avm_write_o; end
        chk("rst_mid:no_rsp", 32'(seen), 0);
        chk("rst_mid:ready", 32'(req_ready_o), 1);

        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            access(st, f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 4),
                   $sformatf("rnd%0d", i), dout);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mod_mem_access_ctrl.md
Name: mod_mem_access_ctrl

Overview:
- Load/store bus sequencer directly downstream of the byte-enable generator in the MEM stage.
- Takes the aligned address, byte enable and funct3 for one access, then runs one Avalon-MM pipelined master transaction.
- Stores: shifts store data into the correct byte lanes.
- Loads: extracts and sign/zero-extends the addressed lanes, returning one registered response to the pipeline.

Parameters:
- DATA_W, `XLEN (32): data and address width. Only 32 is supported.
- BE_W, `BYTEENABLE_WIDTH (4): byte-enable width, equal to DATA_W/8.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  access request
- req_ready_o  out  1  block can accept a request
- req_store_i  in  1  1 = store, 0 = load
- funct3_i  in  `FUNCT3_WIDTH  load/store funct3
- addr_unaligned_i  in  DATA_W  original address; only bits [1:0] are used
- addr_aligned_i  in  DATA_W  word-aligned address from the byte-enable generator
- byteenable_i  in  BE_W  lane enables from the byte-enable generator
- store_data_i  in  DATA_W  rs2 value, right-justified
- avm_address_o  out  DATA_W  bus address
- avm_read_o  out  1  bus read strobe
- avm_write_o  out  1  bus write strobe
- avm_writedata_o  out  DATA_W  lane-shifted store data
- avm_byteenable_o  out  BE_W  bus byte enables
- avm_waitrequest_i  in  1  slave stall
- avm_readdatavalid_i  in  1  read data valid
- avm_readdata_i  in  DATA_W  read data
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_load_data_o  out  DATA_W  extended load result; 0 for stores
- misalign_o  out  1  misaligned-access flag, valid with rsp_valid_o

Behaviour:
- FSM states: IDLE, BUS, RDATA, RESP. Registered state; async reset to IDLE.
- Reset values:
  - req_ready_o = 1 (IDLE).
  - All other outputs 0: avm_read_o, avm_write_o, rsp_valid_o, misalign_o, avm_address_o, avm_writedata_o, avm_byteenable_o, rsp_load_data_o.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch address, byte enable, funct3, offset = addr_unaligned_i[1:0], store flag and store data.
  - byteenable_i == 0 (unsupported funct3): go to RESP, no bus cycle, data 0.
  - Otherwise go to BUS.
- BUS:
  - Exactly one of avm_read_o / avm_write_o = 1.
  - Address, writedata and byte enable are held stable while avm_waitrequest_i = 1.
  - When avm_waitrequest_i = 0: a store goes to RESP; a load goes to RDATA.
- RDATA:
  - Strobes are 0.
  - avm_readdatavalid_i is sampled only in this state; the slave read latency is at least 1 cycle.
  - On readdatavalid, register the extracted data and go to RESP.
- RESP:
  - rsp_valid_o = 1 for exactly one cycle, then return to IDLE.
  - req_ready_o = 0 in every state except IDLE; no request overlap.
- Store lane shift:
  - SB/SH: writedata = store_data_i << (8*offset). Bits shifted past bit 31 are dropped.
  - SW: writedata is unshifted.
- Load extraction: s = avm_readdata_i >> (8*offset).
  - LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
  - LW: s.
- Minimum latency, with the request accepted at cycle T:
  - Store with no wait: rsp_valid_o at T+2.
  - Load with no wait and readdatavalid one cycle after acceptance: rsp_valid_o at T+3.
- Registered bus outputs keep their last values in IDLE; only the strobes are cleared.
- Reset mid-transaction: strobes deassert asynchronously, the transaction is abandoned with no response, and the FSM returns to IDLE. The bus slave shares this reset.
- Unbounded waitrequest stall: the block remains in BUS, with no timeout.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access is LH/LHU/SH with offset[0] = 1, or LW/SW with offset != 0.
  - Such an access skips BUS, goes IDLE -> RESP, and returns rsp_valid_o = 1, misalign_o = 1 and rsp_load_data_o = 0.
  - No bus strobe is asserted.
- Not defined:
  - misalign_o is tied to 0.
  - The access is issued with the byte enables as supplied. Truncated enables, e.g. LH at offset 3 gives 4'b1000, read only the in-word lanes.

Test Plan:
- SB 0x000000AB to address 0x1002, no wait -> avm_write_o = 1 for 1 cycle, avm_address_o = 0x1000, avm_byteenable_o = 4'b0100, avm_writedata_o = 0x00AB0000, rsp_valid_o at T+2.
- LB from 0x2003, readdata 0x80FFFFFF -> rsp_load_data_o = 0xFFFFFF80. The same access with LBU -> 0x00000080.
- LH from 0x2002 with waitrequest held 3 cycles and readdata 0x8001_1234 -> avm_read_o held 4 cycles with stable address, rsp_load_data_o = 0xFFFF8001.
- LW with readdatavalid delayed 5 cycles, then a back-to-back SW -> req_ready_o = 0 until after RESP, one rsp_valid_o pulse per access, LW data returned unmodified.
- rst_ni pulled low during BUS of a store -> avm_write_o drops to 0 in the same cycle, no rsp_valid_o, req_ready_o = 1 after release.
- With MEM_MISALIGN_TRAP_EN defined: LW to 0x3001 -> no strobe, rsp_valid_o = 1 and misalign_o = 1 at T+1. Without the macro: a bus read is issued with byteenable 4'b1111.
